cal_parser: RTL and testbench
=============================

# cal_parser

ASCII expression parser and arithmetic unit of the UART calculator, directly downstream of the UART receiver. It consumes received bytes (`rx_data`/`rx_valid`), accumulates two decimal operands and one operator, and evaluates the expression on `=`. It presents the result with a valid/ack handshake to the transmit-side formatter.

## Interface
- `OPW`, 16: operand, accumulator and result width in bits.
- `MAXDIG`, 5: maximum number of decimal digits per operand.

- `clk`  in  1: system clock (50 MHz).
- `n_rst`  in  1: synchronous, active-low reset.
- `rx_data`  in  8: received byte, stable while `rx_valid` is high.
- `rx_valid`  in  1: byte available; may stay high for many cycles per byte.
- `res_ack`  in  1: consumer accepts the result.
- `res`  out  OPW: result, two's-complement.
- `res_valid`  out  1: result available; held until acknowledged.
- `res_err`  out  1: expression invalid; qualified by `res_valid`.

## Operation
- Byte strobe `stb` = `rx_valid` & ~`rx_valid_d`. `rx_valid_d` is a register with reset value 0. Exactly one strobe occurs per `rx_valid` high period, however long that period lasts.
- States:
  - IDLE: no digit seen.
  - OPA: accumulating A.
  - OPB: operator latched, accumulating B.
  - DONE: result presented.
- Character classes on `stb`:
  - Digit 0x30-0x39. In IDLE, go to OPA. In OPA/OPB, the accumulator becomes acc*10 + (byte−0x30), truncated to OPW bits (modulo 2^OPW, no error). The digit counter increments. A digit that exceeds MAXDIG sets the sticky `err` flag.
  - Operator `+` 0x2B, `-` 0x2D, `*` 0x2A (see Configuration). In OPA with ≥1 digit: latch the operator, clear the digit counter, go to OPB. In IDLE, or in OPB (second operator): set `err`, state unchanged.
  - `=` 0x3D. In OPB with ≥1 B digit: evaluate and go to DONE. In IDLE, in OPA, or in OPB with no B digit: set `err` and go to DONE.
  - Clear `C` 0x43 / `c` 0x63. In IDLE/OPA/OPB: go to IDLE and clear A, B, the operator, the digit counter and `err`.
  - Whitespace 0x20, 0x0A, 0x0D: ignored in every state.
  - Any other byte: set `err`, state unchanged.
- Evaluation, with unsigned operands and the result truncated to OPW bits:
  - `+`: A+B.
  - `-`: A−B, wrapping (3−5 = 0xFFFE).
  - `*`: the low OPW bits of A*B.
  - When `err` is set, `res` = 0 and `res_err` = 1.
- DONE:
  - `res_valid` = 1; `res` and `res_err` are held stable.
  - `res_ack` sampled high: go to IDLE and clear all operand state and `err`.
  - Strobes in DONE are dropped, with no effect.

## Timing
- Reset values: `res` = 0, `res_valid` = 0, `res_err` = 0, state IDLE, accumulators 0, `err` 0, `rx_valid_d` 0. If `rx_valid` is high on the first cycle after reset, that counts as a strobe.
- State and accumulator updates happen on the clock edge at which `rx_valid` is first sampled high.
- `res_valid` rises on the cycle after the edge at which `=` is accepted. `res` and `res_err` are registered and valid in that same cycle.
- `res_valid` falls on the cycle after `res_ack` is sampled high while in DONE. A continuously high `res_ack` gives exactly one DONE cycle.
- `res_ack` is ignored outside DONE.
- `res_ack` and `stb` in the same DONE cycle: the byte is dropped and the state goes to IDLE.
- Reset asserted mid-expression discards the partial expression. `n_rst` low for one edge is sufficient.
- Back-to-back bytes are at most one per `rx_valid` pulse. No minimum gap is required beyond one low cycle of `rx_valid`.

## Configuration
- `CAL_MUL_EN` defined: `*` (0x2A) is a valid operator and the OPW×OPW multiplier is synthesized.
- `CAL_MUL_EN` undefined: `*` is treated as an invalid byte (sets `err`) and no multiplier logic exists.

## Test plan
- "12+34=" → `res` = 0x002E, `res_err` = 0. `res_valid` stays high 10 cycles until `res_ack` pulses, then drops on the next cycle.
- "3-5=" → `res` = 0xFFFE, `res_err` = 0. "65535+1=" → `res` = 0x0000, `res_err` = 0.
- "12*12=" with `CAL_MUL_EN` → `res` = 0x0090, `res_err` = 0. Without it → `res` = 0, `res_err` = 1.
- Invalid expressions → `res_err` = 1 and `res` = 0 for each:
  - "123456+1=" (6 digits);
  - "+3=";
  - "1+=";
  - "1++2=";
  - "1?2=".
- Clear and reset recovery:
  - "1+2C4+4=" → `res` = 8.
  - "12+", then `n_rst` low for one cycle, then "1+1=" → `res` = 2.
  - Spaces and CR/LF inside "1 + 1\r=" → `res` = 2.
- Strobe handling:
  - Each byte with `rx_valid` held high for 434 cycles → exactly one byte consumed.
  - Bytes sent while in DONE are dropped; after `res_ack`, "2+2=" → `res` = 4.

Source files
------------

// File: rtl/cal_parser.sv
// cal_parser: ASCII expression parser and arithmetic unit for the UART
// calculator. Consumes received bytes, accumulates operand A, an operator
// and operand B, and evaluates on '='. The result is presented with a
// valid/ack handshake.
//
// Build option: define CAL_MUL_EN to accept '*' and build the multiplier.
// Without it, '*' is an invalid byte and no multiplier exists.
module cal_parser #(
  parameter int OPW    = 16,
  parameter int MAXDIG = 5
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic           res_ack,
  output logic [OPW-1:0] res,
  output logic           res_valid,
  output logic           res_err
);

  // Digit counter saturates at MAXDIG+1, which is enough to flag overflow.
  localparam int CW = $clog2(MAXDIG + 2);

  typedef enum logic [1:0] {IDLE, OPA, OPB, DONE} state_t;
  typedef enum logic [2:0] {C_DIG, C_OP, C_EQ, C_CLR, C_WS, C_BAD} cls_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t         state;
  op_t            op;
  logic [OPW-1:0] acc_a;
  logic [OPW-1:0] acc_b;
  logic [CW-1:0]  cnt;
  logic           err;
  logic           rx_valid_d;

  // One strobe per rx_valid high period, however long it lasts.
  logic stb;
  assign stb = rx_valid & ~rx_valid_d;

  cls_t cls;
  op_t  opc;

  // Classify the received byte.
  always_comb begin
    cls = C_BAD;
    opc = OP_ADD;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      cls = C_DIG;
    end else begin
      case (rx_data)
        8'h2B: begin cls = C_OP; opc = OP_ADD; end
        8'h2D: begin cls = C_OP; opc = OP_SUB; end
`ifdef CAL_MUL_EN
        8'h2A: begin cls = C_OP; opc = OP_MUL; end
`endif
        8'h3D:               cls = C_EQ;
        8'h43, 8'h63:        cls = C_CLR;
        8'h20, 8'h0A, 8'h0D: cls = C_WS;
        default:             cls = C_BAD;
      endcase
    end
  end

  logic [OPW-1:0] acc_src;
  logic [OPW-1:0] acc_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic           dig_over;
  logic [3:0]     dval;

  // Next accumulator/digit-count values for a digit byte. The low nibble of
  // an ASCII digit is its value. In IDLE the accumulation starts from zero.
  always_comb begin
    dval     = rx_data[3:0];
    acc_src  = (state == OPB) ? acc_b : ((state == OPA) ? acc_a : '0);
    acc_nxt  = acc_src * OPW'(10) + {{(OPW-4){1'b0}}, dval};
    if (state == IDLE)
      cnt_nxt = CW'(1);
    else if (cnt == CW'(MAXDIG + 1))
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + CW'(1);
    dig_over = (cnt_nxt > CW'(MAXDIG));
  end

  logic [OPW-1:0] eval;

  // Evaluate A op B, unsigned, truncated to OPW bits.
  always_comb begin
    case (op)
      OP_ADD:  eval = acc_a + acc_b;
      OP_SUB:  eval = acc_a - acc_b;
`ifdef CAL_MUL_EN
      OP_MUL:  eval = acc_a * acc_b;
`endif
      default: eval = '0;
    endcase
  end

  // Parser FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      op         <= OP_ADD;
      acc_a      <= '0;
      acc_b      <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      rx_valid_d <= 1'b0;
      res        <= '0;
      res_valid  <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      case (state)
        // Strobes are dropped here; only the ack matters.
        DONE: begin
          if (res_ack) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            op        <= OP_ADD;
            acc_a     <= '0;
            acc_b     <= '0;
            cnt       <= '0;
            err       <= 1'b0;
          end
        end
        default: begin
          if (stb) begin
            case (cls)
              C_DIG: begin
                if (state == IDLE) state <= OPA;
                if (state == OPB) acc_b <= acc_nxt;
                else              acc_a <= acc_nxt;
                cnt <= cnt_nxt;
                if (dig_over) err <= 1'b1;
              end
              C_OP: begin
                if (state == OPA && cnt != '0) begin
                  op    <= opc;
                  cnt   <= '0;
                  state <= OPB;
                end else begin
                  err <= 1'b1;
                end
              end
              C_EQ: begin
                state     <= DONE;
                res_valid <= 1'b1;
                if (state == OPB && cnt != '0 && !err) begin
                  res     <= eval;
                  res_err <= 1'b0;
                end else begin
                  res     <= '0;
                  res_err <= 1'b1;
                end
              end
              C_CLR: begin
                state <= IDLE;
                op    <= OP_ADD;
                acc_a <= '0;
                acc_b <= '0;
                cnt   <= '0;
                err   <= 1'b0;
              end
              C_WS: ;
              default: err <= 1'b1;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cal_parser.sv
// Testbench for cal_parser: table-driven expressions with a scoreboard
// queue, plus hand-written handshake, strobe and reset sequences.
module tb_cal_parser;

  localparam int OPW = 16;

  logic           clk = 1'b0;
  logic           n_rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           res_ack;
  logic [OPW-1:0] res;
  logic           res_valid;
  logic           res_err;

  cal_parser #(.OPW(OPW), .MAXDIG(5)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .res_ack(res_ack), .res(res), .res_valid(res_valid), .res_err(res_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t vecs[$];

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  always @(negedge clk) if (res_valid === 1'b1) vcount++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string s, input logic [15:0] r, input logic e);
    exp_t v;
    v.name = s; v.res = r; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) tick;
    rx_valid = 1'b0;
    tick;
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold);
  endtask

  task automatic expect_res(input string s, input logic [15:0] r, input logic e);
    exp_t x;
    x.name = s; x.res = r; x.err = e;
    sb.push_back(x);
  endtask

  task automatic run_expr(input string s, input logic [15:0] r, input logic e);
    expect_res(s, r, e);
    send_str(s, 1);
  endtask

  // Wait (bounded) for a result, compare against the scoreboard head, check
  // it holds for hold_cycles, then optionally acknowledge it.
  task automatic wait_result(input int hold_cycles, input bit do_ack);
    exp_t x;
    int   n;
    int   bad;
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin tick; n++; end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    x = sb.pop_front();
    if (res_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL timeout %s: got no res_valid expected res_valid within 200 cycles", x.name);
      return;
    end
    check({x.name, " res"}, 32'(res), 32'(x.res));
    check({x.name, " res_err"}, 32'(res_err), 32'(x.err));
    if (hold_cycles > 0) begin
      bad = 0;
      repeat (hold_cycles) begin
        tick;
        if (res_valid !== 1'b1 || res !== x.res || res_err !== x.err) bad++;
      end
      check({x.name, " held"}, 32'(bad), 32'd0);
    end
    if (do_ack) begin
      res_ack = 1'b1;
      tick;
      res_ack = 1'b0;
      check({x.name, " valid after ack"}, 32'(res_valid), 32'd0);
    end
  endtask

  initial begin
    n_rst    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    res_ack  = 1'b0;
    repeat (3) tick;
    check("reset res", 32'(res), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_err", 32'(res_err), 32'd0);

    // rx_valid already high on the first cycle out of reset is a strobe.
    rx_data  = 8'h35;
    rx_valid = 1'b1;
    tick;
    n_rst = 1'b1;
    tick;
    rx_valid = 1'b0;
    tick;
    expect_res("first-cycle strobe 5+1=", 16'd6, 1'b0);
    send_str("+1=", 1);
    wait_result(0, 1);

    // Main example, result held 10 cycles before the ack.
    run_expr("12+34=", 16'h002E, 1'b0);
    wait_result(10, 1);

    add_vec("3-5=",        16'hFFFE, 1'b0);
    add_vec("65535+1=",    16'h0000, 1'b0);
`ifdef CAL_MUL_EN
    add_vec("12*12=",      16'h0090, 1'b0);
`else
    add_vec("12*12=",      16'h0000, 1'b1);
`endif
    add_vec("123456+1=",   16'h0000, 1'b1);
    add_vec("+3=",         16'h0000, 1'b1);
    add_vec("1+=",         16'h0000, 1'b1);
    add_vec("1++2=",       16'h0000, 1'b1);
    add_vec("1?2=",        16'h0000, 1'b1);
    add_vec("1=",          16'h0000, 1'b1);
    add_vec("=",           16'h0000, 1'b1);
    add_vec("1+2C4+4=",    16'd8,    1'b0);
    add_vec("c5+5=",       16'd10,   1'b0);
    add_vec("1 + 1\015=",  16'd2,    1'b0);
    add_vec("1\012+\0122=", 16'd3,   1'b0);
    add_vec("200-1=",      16'h00C7, 1'b0);
    add_vec("12345+54321=", 16'h046A, 1'b0);
    add_vec("99999+0=",    16'h869F, 1'b0);
    add_vec("4+4 =",       16'd8,    1'b0);

    foreach (vecs[i]) begin
      run_expr(vecs[i].name, vecs[i].res, vecs[i].err);
      wait_result(0, 1);
    end

    // Reset mid-expression discards the partial expression.
    send_str("12+", 1);
    n_rst = 1'b0;
    tick;
    n_rst = 1'b1;
    check("mid reset res_valid", 32'(res_valid), 32'd0);
    run_expr("1+1= after reset", 16'd2, 1'b0);
    wait_result(0, 1);

    // Each byte held for 434 cycles is consumed once.
    expect_res("long rx_valid 7+8=", 16'd15, 1'b0);
    send_str("7+8=", 434);
    wait_result(0, 1);

    // Continuously high ack gives exactly one DONE cycle.
    res_ack = 1'b1;
    vcount  = 0;
    send_str("4+5=", 1);
    repeat (3) tick;
    res_ack = 1'b0;
    check("held ack valid cycles", 32'(vcount), 32'd1);
    check("held ack res", 32'(res), 32'd9);
    check("held ack valid low", 32'(res_valid), 32'd0);

    // Bytes in DONE are dropped, including one arriving with the ack.
    run_expr("5+5=", 16'd10, 1'b0);
    wait_result(0, 0);
    send_str("9+", 1);
    check("done drop res", 32'(res), 32'd10);
    check("done drop valid", 32'(res_valid), 32'd1);
    rx_data  = 8'h35;
    rx_valid = 1'b1;
    res_ack  = 1'b1;
    tick;
    rx_valid = 1'b0;
    res_ack  = 1'b0;
    tick;
    check("ack+stb valid", 32'(res_valid), 32'd0);
    run_expr("2+2= after done", 16'd4, 1'b0);
    wait_result(0, 1);

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
